// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver with majority vote, error detection and valid/ready output
// Optional parity check is built only when UART_RX_PARITY_EN is defined.
module uart_rx_param #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 break_det,
  output logic                 overrun
);
  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int IW  = $clog2(DATA_BITS);
  localparam logic [OW-1:0] S_LO  = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] S_MID = OW'(OVERSAMPLE / 2);
  localparam logic [OW-1:0] S_HI  = OW'(OVERSAMPLE / 2 + 1);
  localparam logic [OW-1:0] S_END = OW'(OVERSAMPLE - 1);
  if (DIV < 1 || OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
    $error("uart_rx_param: illegal parameter combination");
  end
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_IDLE
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;
  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_sync_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OW-1:0]        os_q, os_d;
  logic [1:0]           samp_q, samp_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 fe_q, fe_d, bd_q, bd_d, ov_q, ov_d;
  logic                 tick, eval, maj, deliver, load;
`ifdef UART_RX_PARITY_EN
  logic                 par_err_q, par_err_d, pe_q, pe_d;
`endif
  assign tick = cnt_q == CW'(DIV - 1);
  assign eval = tick && os_q == S_HI;
  assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);
  // Two-flop synchronizer, reset to the idle (high) line level
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) {rx_sync_q, rx_meta_q} <= 2'b11;
    else       {rx_sync_q, rx_meta_q} <= {rx_meta_q, rx};
  // Tick divider and oversample position, both held cleared while idle so a start edge restarts them
  always_comb begin
    cnt_d  = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
    os_d   = (state_q == IDLE) ? '0 : !tick ? os_q : (os_q == S_END) ? '0 : os_q + 1'b1;
    samp_d = {(tick && os_q == S_MID) ? rx_sync_q : samp_q[1], (tick && os_q == S_LO) ? rx_sync_q : samp_q[0]};
  end
  // Frame FSM: next state, payload assembly and per-frame error pulses (break > frame > parity)
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    fe_d    = 1'b0;
    bd_d    = 1'b0;
    deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
    pe_d      = 1'b0;
`endif
    case (state_q)
      IDLE: if (!rx_sync_q) begin
        state_d = START;
        idx_d   = '0;
        stop_d  = 1'b0;
        shift_d = '0;
`ifdef UART_RX_PARITY_EN
        par_err_d = 1'b0;
`endif
      end
      START: if (eval) state_d = maj ? IDLE : DATA;
      DATA: if (eval) begin
        shift_d[idx_q] = maj;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(DATA_BITS - 1)) begin
          idx_d = '0;
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (eval) begin
        par_err_d = ^shift_q ^ maj ^ 1'(PARITY_ODD);
        state_d   = STOP;
      end
`endif
      STOP: if (eval) begin
        if (!maj) begin
          bd_d    = shift_q == '0;
          fe_d    = shift_q != '0;
          state_d = WAIT_IDLE;
        end else if (stop_q == 1'(STOP_BITS - 1)) begin
          state_d = IDLE;
`ifdef UART_RX_PARITY_EN
          pe_d    = par_err_q;
          deliver = !par_err_q;
`else
          deliver = 1'b1;
`endif
        end else stop_d = 1'b1;
      end
      WAIT_IDLE: if (rx_sync_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Output handshake: load a good frame if the slot is free or being accepted, otherwise drop it and flag overrun
  always_comb begin
    load       = deliver && (!rx_valid_q || rx_ready);
    rx_valid_d = load || (rx_valid_q && !rx_ready);
    rx_data_d  = load ? shift_q : rx_data_q;
    ov_d       = deliver && !load;
  end
  // State and output registers
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      os_q       <= '0;
      samp_q     <= '0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      fe_q       <= 1'b0;
      bd_q       <= 1'b0;
      ov_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= 1'b0;
      pe_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      os_q       <= os_d;
      samp_q     <= samp_d;
      idx_q      <= idx_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      fe_q       <= fe_d;
      bd_q       <= bd_d;
      ov_q       <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= par_err_d;
      pe_q       <= pe_d;
`endif
    end
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = state_q != IDLE;
  assign frame_err = fe_q;
  assign break_det = bd_q;
  assign overrun   = ov_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised, oversampling UART receiver; successor to the fixed 8N1 9600-baud receiver on the 12 MHz board clock.
- Adds generic clock/baud/width/stop-bit settings, a 3-sample majority vote, and glitch rejection on the start bit.
- Adds framing, break and overrun detection, plus a valid/ready output handshake.
- Sits between the board RX pin and the byte-consuming logic (command parser or FIFO).

Parameters:
- CLK_FREQ, 12000000, system clock in Hz.
- BAUD, 9600, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit; even, >= 8.
- DATA_BITS, 8, payload width, 5..9, LSB first.
- STOP_BITS, 1, number of stop bits, 1 or 2.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity. Used only when UART_RX_PARITY_EN is defined.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- nrst  in  1  asynchronous, active-low reset.
- rx  in  1  asynchronous serial input; idle level is high.
- rx_data  out  DATA_BITS  received payload; valid while rx_valid is high.
- rx_valid  out  1  payload available; held until accepted.
- rx_ready  in  1  consumer accepts on the cycle where rx_valid && rx_ready.
- busy  out  1  high from start-bit detect until return to IDLE.
- frame_err  out  1  one-cycle pulse: a stop bit was sampled 0.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- break_det  out  1  one-cycle pulse: framing error with all-zero payload.
- overrun  out  1  one-cycle pulse: good frame completed while the previous one was still unaccepted.

Behaviour:
- Reset: all outputs 0. rx_data = 0. The 2-flop synchronizer on rx resets to 1. FSM goes to IDLE and the tick divider clears. Reset mid-frame discards the partial frame, with no pulses.
- Tick generator: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), truncated; defaults give 78. A one-clock tick pulse fires every DIV clocks. The divider restarts on the falling-edge detect in IDLE.
- Sampling: inside each bit, samples are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2-of-3 majority, evaluated at tick OVERSAMPLE/2+1.
- FSM states and transitions:
  - IDLE: when synchronized rx = 0, go to START and set busy = 1.
  - START: if the majority is 1 (glitch), go back to IDLE with busy = 0 and no pulse. Otherwise go to DATA, bit index = 0.
  - DATA: shift the majority into bit [index]. After DATA_BITS bits, go to PARITY (macro defined) or to STOP.
  - PARITY: compute the check bit; a mismatch latches an internal error flag.
  - STOP: evaluate STOP_BITS stop bits.
    - Any stop bit = 0: pulse frame_err, or pulse break_det instead if payload == 0. Go to WAIT_IDLE.
    - All stop bits = 1 with the parity flag set: pulse parity_err, go to IDLE.
    - Otherwise deliver the frame and go to IDLE.
  - WAIT_IDLE: stay until synchronized rx = 1, then go to IDLE. A long break produces exactly one break_det.
- Latency and back-to-back: delivery happens on the clock after the last stop-bit evaluation, at mid-stop-bit. busy drops on that same clock. A start edge arriving half a bit later is detected normally, so frames can run back-to-back.
- Delivery:
  - If rx_valid = 0, or rx_valid && rx_ready in the same cycle: load rx_data and set rx_valid = 1.
  - Else: pulse overrun; rx_data and rx_valid stay unchanged and the new frame is dropped.
  - rx_valid clears on handshake unless a new delivery happens in the same cycle.
- Only one error pulse is raised per frame. Priority: break_det > frame_err > parity_err. An errored frame never asserts rx_valid.

Optional Feature:
- UART_RX_PARITY_EN defined: one parity bit follows the payload, checked against PARITY_ODD.
- Not defined: no PARITY state is built, parity_err is tied to 0, and PARITY_ODD is ignored.

Test Plan:
- 8N1 byte 0x53 at default parameters (1248 clocks/bit); hold rx_ready low for 3 cycles after rx_valid → rx_data = 0x53 and rx_valid stays high until the handshake; no error pulses; busy drops mid-stop-bit.
- Back-to-back 0x6E then 0x61 with no idle gap, rx_ready tied to 1 → two rx_valid pulses, data 0x6E then 0x61; overrun = 0.
- rx low for 300 clocks (less than the 624-clock half bit), then high → busy pulses briefly; no rx_valid and no error pulses; FSM returns to IDLE.
- Byte 0xA5 with stop bit driven 0 → frame_err for one cycle, no rx_valid. Then rx held low for 30000 clocks → exactly one break_det; busy stays high until rx returns high.
- rx_ready held 0, send 0x11 then 0x22 → rx_data stays 0x11 and rx_valid stays 1; overrun pulses once at the second frame's mid-stop-bit.
- Macro defined, PARITY_ODD = 0, send 0x53 with parity bit 1 (correct is 0) → parity_err pulses once and rx_valid stays 0. Resending 0x53 with parity bit 0 → rx_data = 0x53 is delivered.
